breathing_led_pwm: RTL

Consumes the slow divided clock produced by the clock divider, clocked by clk_in. Synchronises the slow clock and edge-detects it into single-cycle ticks. Uses those ticks to step a duty-cycle ramp state machine that drives a glitch-free PWM output for a "breathing" LED on the board.

---
 rtl/breathing_led_pwm_if.sv | 22 ++
 rtl/breathing_led_pwm.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/breathing_led_pwm_if.sv
// Signal bundle between the breathing-LED PWM block and its surroundings:
// slow clock and enable in; PWM, duty, tick and phase out.
interface breathing_led_pwm_if #(
    parameter int PWM_W = 8
);
    logic             slow_clk;
    logic             enable;
    logic             pwm_out;
    logic [PWM_W-1:0] duty;
    logic             tick_out;
    logic [2:0]       phase;

    modport master (
        output slow_clk, enable,
        input  pwm_out, duty, tick_out, phase
    );

    modport slave (
        input  slow_clk, enable,
        output pwm_out, duty, tick_out, phase
    );
endinterface

// File: rtl/breathing_led_pwm.sv
// Breathing LED: synchronises a slow clock into ticks that step a duty ramp
// feeding a glitch-free PWM. Define BREATH_BOTH_EDGES_EN to tick on both slow_clk edges.
module breathing_led_pwm #(
    parameter int PWM_W      = 8,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 4
) (
    input  logic                clk_in,
    input  logic                reset_n,
    breathing_led_pwm_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } phase_e;

    localparam int               HOLD_W    = $clog2(HOLD_TICKS + 1);
    localparam logic [PWM_W-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_W:0]   STEP_X    = (PWM_W + 1)'(STEP);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    logic             s1_q, s2_q, s3_q;
    logic             tick;
    logic [PWM_W-1:0] pwm_cnt_q;
    logic [PWM_W-1:0] duty_active_q;
    logic             pwm_out_q;
    phase_e           state_q, state_d;
    logic [PWM_W-1:0] duty_target_q, duty_target_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [PWM_W:0]   sum_x, diff_x;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.slow_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

`ifdef BREATH_BOTH_EDGES_EN
    assign tick = s2_q ^ s3_q;
`else
    assign tick = s2_q & ~s3_q;
`endif

    // duty_active only reloads on the last count so each period is drawn with one duty.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q     <= '0;
            duty_active_q <= '0;
            pwm_out_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            pwm_out_q <= (pwm_cnt_q < duty_active_q);
            if (pwm_cnt_q == DUTY_MAX) begin
                duty_active_q <= duty_target_q;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            duty_target_q <= '0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            duty_target_q <= duty_target_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    // One extra bit catches overflow past MAX and borrow below zero.
    assign sum_x  = {1'b0, duty_target_q} + STEP_X;
    assign diff_x = {1'b0, duty_target_q} - STEP_X;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        duty_target_d = duty_target_q;
        hold_cnt_d    = hold_cnt_q;
        if (tick) begin
            if (!bus.enable) begin
                state_d       = IDLE;
                duty_target_d = '0;
                hold_cnt_d    = '0;
            end else begin
                case (state_q)
                    IDLE: state_d = UP;
                    UP: begin
                        if (sum_x >= {1'b0, DUTY_MAX}) begin
                            duty_target_d = DUTY_MAX;
                            state_d       = HOLD_HI;
                            hold_cnt_d    = '0;
                        end else begin
                            duty_target_d = sum_x[PWM_W-1:0];
                        end
                    end
                    HOLD_HI: begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d    = DOWN;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                    DOWN: begin
                        if (diff_x[PWM_W] || (diff_x == '0)) begin
                            duty_target_d = '0;
                            state_d       = HOLD_LO;
                            hold_cnt_d    = '0;
                        end else begin
                            duty_target_d = diff_x[PWM_W-1:0];
                        end
                    end
                    HOLD_LO: begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d    = UP;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_d       = IDLE;
                        duty_target_d = '0;
                        hold_cnt_d    = '0;
                    end
                endcase
            end
        end
    end

    assign bus.pwm_out  = pwm_out_q;
    assign bus.duty     = duty_active_q;
    assign bus.tick_out = tick;
    assign bus.phase    = state_q;

endmodule
